rvvi_retire_tx: RTL and testbench

Transmitter end of the RVVI retirement interface for a single-hart, single-issue core. It accepts one compact retire record per instruction from the core's commit stage over a valid/ready handshake and buffers records in a small FIFO. It drives the RVVI signal set: a per-retirement `valid` pulse, a gap-free `order` count, full shadow X (and optionally F) register files with writeback flags, and a derived `intr` flag. It sits between the core's commit logic and the RVVI interface instance consumed by the tracer/comparator.

---
 rtl/rvvi_retire_tx.sv | 166 ++++++++++++++++
 tb/tb_rvvi_retire_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_retire_tx.sv
// rvvi_retire_tx: RVVI retirement transmitter (record FIFO, shadow register files, halt FSM); F file built only with RVVI_RETIRE_TX_FREG_EN defined
module rvvi_retire_tx #(
  parameter int ILEN  = 32,
  parameter int XLEN  = 32,
  parameter int FLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [ILEN-1:0]             in_insn_i,
  input  logic [XLEN-1:0]             in_pc_rdata_i,
  input  logic [XLEN-1:0]             in_pc_wdata_i,
  input  logic                        in_trap_i,
  input  logic                        in_halt_i,
  input  logic [1:0]                  in_mode_i,
  input  logic                        in_rd_we_i,
  input  logic [4:0]                  in_rd_i,
  input  logic [XLEN-1:0]             in_rd_wdata_i,
`ifdef RVVI_RETIRE_TX_FREG_EN
  input  logic                        in_frd_we_i,
  input  logic [4:0]                  in_frd_i,
  input  logic [FLEN-1:0]             in_frd_wdata_i,
  output logic [31:0][FLEN-1:0]       f_wdata_o,
  output logic [31:0]                 f_wb_o,
`endif
  input  logic                        hold_i,
  output logic                        valid_o,
  output logic [63:0]                 order_o,
  output logic [ILEN-1:0]             insn_o,
  output logic                        trap_o,
  output logic                        halt_o,
  output logic                        intr_o,
  output logic [1:0]                  mode_o,
  output logic [1:0]                  ixl_o,
  output logic [XLEN-1:0]             pc_rdata_o,
  output logic [XLEN-1:0]             pc_wdata_o,
  output logic [31:0][XLEN-1:0]       x_wdata_o,
  output logic [31:0]                 x_wb_o,
  output logic                        halted_o,
  output logic [$clog2(DEPTH):0]      count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            trap;
    logic            halt;
    logic [1:0]      mode;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_wdata;
`ifdef RVVI_RETIRE_TX_FREG_EN
    logic            frd_we;
    logic [4:0]      frd;
    logic [FLEN-1:0] frd_wdata;
`endif
  } rec_t;
  typedef enum logic {RUN, HALTED} state_e;
  state_e          state_q, state_d;
  rec_t            mem_q [DEPTH];
  rec_t            in_rec, head;
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, xw, intr_q;
  assign head       = mem_q[rd_q];
  assign halted_o   = state_q == HALTED;
  assign in_ready_o = !halted_o && count_q != FULL;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = count_q != '0 && !hold_i && !halted_o;
  assign xw         = pop && head.rd_we && head.rd != 5'd0 && !head.trap;
  assign count_o    = count_q;
  assign ixl_o      = XLEN == 64 ? 2'd2 : 2'd1;
  // pack the incoming record for storage
  always_comb begin
    in_rec          = '0;
    in_rec.insn     = in_insn_i;
    in_rec.pc_rdata = in_pc_rdata_i;
    in_rec.pc_wdata = in_pc_wdata_i;
    in_rec.trap     = in_trap_i;
    in_rec.halt     = in_halt_i;
    in_rec.mode     = in_mode_i;
    in_rec.rd_we    = in_rd_we_i;
    in_rec.rd       = in_rd_i;
    in_rec.rd_wdata = in_rd_wdata_i;
`ifdef RVVI_RETIRE_TX_FREG_EN
    in_rec.frd_we    = in_frd_we_i;
    in_rec.frd       = in_frd_i;
    in_rec.frd_wdata = in_frd_wdata_i;
`endif
  end
  // next state and occupancy: halting latches forever, HALTED flushes the FIFO
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && pop && head.halt) state_d = HALTED;
    count_d = halted_o ? '0 :
              (push && !pop) ? count_q + CW'(1) :
              (pop && !push) ? count_q - CW'(1) : count_q;
  end
  // record storage; contents are meaningless outside the occupied window so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_rec;
  end
  // FIFO pointers, occupancy and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_q <= wr_q + 1'b1;
      rd_q <= halted_o ? wr_q : pop ? rd_q + 1'b1 : rd_q;
    end
  end
  // RVVI outputs: register the popped record, update shadow file, track pending interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      order_o    <= '0;
      insn_o     <= '0;
      trap_o     <= 1'b0;
      halt_o     <= 1'b0;
      intr_o     <= 1'b0;
      mode_o     <= 2'b11;
      pc_rdata_o <= '0;
      pc_wdata_o <= '0;
      x_wdata_o  <= '0;
      x_wb_o     <= '0;
      intr_q     <= 1'b0;
    end else begin
      valid_o <= pop;
      intr_o  <= pop && intr_q;
      x_wb_o  <= xw ? 32'd1 << head.rd : '0;
      if (pop) begin
        order_o    <= order_o + 64'd1;
        insn_o     <= head.insn;
        trap_o     <= head.trap;
        halt_o     <= head.halt;
        mode_o     <= head.mode;
        pc_rdata_o <= head.pc_rdata;
        pc_wdata_o <= head.pc_wdata;
        intr_q     <= head.trap;
      end
      if (xw) x_wdata_o[head.rd] <= head.rd_wdata;
    end
  end
`ifdef RVVI_RETIRE_TX_FREG_EN
  // F shadow file: same rules as X except f0 is an ordinary register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wdata_o <= '0;
      f_wb_o    <= '0;
    end else begin
      f_wb_o <= (pop && head.frd_we && !head.trap) ? 32'd1 << head.frd : '0;
      if (pop && head.frd_we && !head.trap) f_wdata_o[head.frd] <= head.frd_wdata;
    end
  end
`endif
endmodule

// File: tb/tb_rvvi_retire_tx.sv
// tb_rvvi_retire_tx: randomized and directed bench with a queue-based reference model
module tb_rvvi_retire_tx;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [31:0] insn, pcr, pcw, wd;
    logic        trap, halt, we;
    logic [1:0]  mode;
    logic [4:0]  rd;
  } rec_t;
  logic clk = 0, rst_n = 1, in_valid = 0, hold = 0;
  rec_t cur = '0;
  logic in_ready, valid, trap, halt, intr, halted;
  logic [63:0] order;
  logic [31:0] insn, pc_rdata, pc_wdata, x_wb;
  logic [1:0] mode, ixl;
  logic [31:0][31:0] x_wdata;
  logic [2:0] count;
  int n_chk = 0, n_err = 0;
  rec_t q[$];
  bit m_halted, m_flag, last_acc;
  logic [63:0] e_order;
  logic e_valid, e_intr, e_trap, e_halt;
  logic [31:0] e_xwb, e_insn, e_pcr, e_pcw;
  logic [1:0] e_mode;
  logic [31:0] mx [32];

  always #5 clk = ~clk;

  rvvi_retire_tx #(.ILEN(32), .XLEN(32), .FLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_insn_i(cur.insn), .in_pc_rdata_i(cur.pcr), .in_pc_wdata_i(cur.pcw),
    .in_trap_i(cur.trap), .in_halt_i(cur.halt), .in_mode_i(cur.mode),
    .in_rd_we_i(cur.we), .in_rd_i(cur.rd), .in_rd_wdata_i(cur.wd),
    .hold_i(hold), .valid_o(valid), .order_o(order), .insn_o(insn),
    .trap_o(trap), .halt_o(halt), .intr_o(intr), .mode_o(mode), .ixl_o(ixl),
    .pc_rdata_o(pc_rdata), .pc_wdata_o(pc_wdata), .x_wdata_o(x_wdata),
    .x_wb_o(x_wb), .halted_o(halted), .count_o(count)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(logic [31:0] i, logic [31:0] pc, logic we, logic [4:0] rd,
                              logic [31:0] wd, logic tr, logic hl);
    rec_t r;
    r.insn = i; r.pcr = pc; r.pcw = pc + 4; r.we = we; r.rd = rd; r.wd = wd;
    r.trap = tr; r.halt = hl; r.mode = 2'b11;
    return r;
  endfunction

  function automatic rec_t rnd();
    rec_t r;
    r.insn = $urandom; r.pcr = $urandom; r.pcw = r.pcr + 4; r.wd = $urandom;
    r.trap = $urandom_range(0, 5) == 0; r.halt = 0; r.we = 1'($urandom_range(0, 1));
    r.mode = 2'($urandom_range(0, 3)); r.rd = 5'($urandom_range(0, 31));
    return r;
  endfunction

  task automatic model_reset();
    q.delete(); m_halted = 0; m_flag = 0; e_order = 0; e_valid = 0; e_intr = 0;
    e_trap = 0; e_halt = 0; e_xwb = 0; e_insn = 0; e_pcr = 0; e_pcw = 0; e_mode = 2'b11;
    foreach (mx[i]) mx[i] = 0;
  endtask

  task automatic cmp_all();
    chk("valid", valid, e_valid);
    chk("order", order, e_order);
    chk("insn", insn, e_insn);
    chk("pc_rdata", pc_rdata, e_pcr);
    chk("pc_wdata", pc_wdata, e_pcw);
    chk("trap", trap, e_trap);
    chk("halt", halt, e_halt);
    chk("intr", intr, e_intr);
    chk("mode", mode, e_mode);
    chk("x_wb", x_wb, e_xwb);
    chk("halted", halted, m_halted);
    chk("count", count, q.size());
    chk("in_ready", in_ready, !m_halted && q.size() < DEPTH);
    chk("ixl", ixl, 1);
    for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), x_wdata[i], mx[i]);
  endtask

  task automatic cyc();
    bit pu, po;
    rec_t r;
    @(posedge clk);
    pu = in_valid && !m_halted && q.size() < DEPTH;
    po = q.size() > 0 && !hold && !m_halted;
    e_valid = 0; e_xwb = 0; e_intr = 0;
    if (m_halted) q.delete();
    if (po) begin
      r = q.pop_front();
      e_valid = 1; e_order++; e_insn = r.insn; e_pcr = r.pcr; e_pcw = r.pcw;
      e_trap = r.trap; e_halt = r.halt; e_mode = r.mode;
      e_intr = m_flag; m_flag = r.trap;
      if (r.we && r.rd != 0 && !r.trap) begin
        e_xwb = 32'd1 << r.rd;
        mx[r.rd] = r.wd;
      end
      if (r.halt) m_halted = 1;
    end
    if (pu) q.push_back(cur);
    last_acc = pu;
    @(negedge clk);
    cmp_all();
  endtask

  task automatic push(rec_t r);
    cur = r; in_valid = 1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (last_acc) break;
    end
    chk("accept_timeout", last_acc, 1);
    in_valid = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_order", order, 0);
    chk("rst_mode", mode, 3);
    chk("rst_count", count, 0);
    chk("rst_halted", halted, 0);
    in_valid = 0; hold = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cmp_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    push(mk(32'h00500093, 32'h0, 1, 5'd1, 32'd5, 0, 0));
    push(mk(32'h00700113, 32'h4, 1, 5'd2, 32'd7, 0, 0));
    push(mk(32'h00000013, 32'h8, 0, 5'd0, 32'd0, 0, 0));
    repeat (3) cyc();
    chk("p1_x1", x_wdata[1], 5);
    chk("p1_x2", x_wdata[2], 7);
    chk("p1_order", order, 3);
    push(mk(32'h00000033, 32'hc, 1, 5'd0, 32'hdead, 0, 0));
    push(mk(32'h00000073, 32'h10, 1, 5'd3, 32'h1234, 1, 0));
    repeat (3) cyc();
    chk("p2_x0", x_wdata[0], 0);
    chk("p2_x3", x_wdata[3], 0);
    push(mk(32'h00000013, 32'h14, 0, 5'd0, 32'd0, 0, 0));
    push(mk(32'h00000073, 32'h100, 0, 5'd0, 32'd0, 1, 0));
    push(mk(32'h00000013, 32'h200, 0, 5'd0, 32'd0, 0, 0));
    push(mk(32'h00000013, 32'h204, 0, 5'd0, 32'd0, 0, 0));
    repeat (3) cyc();
    do_reset();
    hold = 1;
    repeat (4) push(rnd());
    chk("p4_count", count, 4);
    cur = rnd(); in_valid = 1;
    repeat (3) cyc();
    chk("p4_ready", in_ready, 0);
    hold = 0;
    push(cur);
    push(rnd());
    repeat (8) cyc();
    chk("p4_order", order, 6);
    for (int i = 0; i < 400; i++) begin
      hold = $urandom_range(0, 3) == 0;
      in_valid = 1'($urandom_range(0, 1));
      cur = rnd();
      cyc();
    end
    hold = 0; in_valid = 0;
    repeat (8) cyc();
    hold = 1;
    push(mk(32'h00100073, 32'h300, 1, 5'd5, 32'h55, 0, 1));
    push(rnd());
    push(rnd());
    hold = 0; cur = rnd(); in_valid = 1;
    repeat (25) cyc();
    in_valid = 0;
    chk("p6_halted", halted, 1);
    chk("p6_count", count, 0);
    do_reset();
    push(rnd());
    push(rnd());
    repeat (3) cyc();
    hold = 1;
    repeat (3) push(rnd());
    chk("p7_count", count, 3);
    do_reset();
    push(rnd());
    repeat (3) cyc();
    chk("p7_order", order, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
